// File: rtl/pipe_hazard_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard entry layout,
// forward-select type and the writer predicate.
package pipe_hazard_pkg;

  // Register addresses are carried zero-extended to this width inside the scoreboard.
  localparam int unsigned SB_AW     = 8;
  localparam int unsigned FWD_SEL_W = 4;

  typedef logic [FWD_SEL_W-1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_IDFILE = '0;

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic [SB_AW-1:0] dest;
    logic             is_load;
    logic [SB_AW-1:0] rs;
    logic [SB_AW-1:0] rt;
    logic             uses_rs;
    logic             uses_rt;
  } sb_entry_t;

  function automatic logic is_writer(sb_entry_t e);
    return e.valid & e.regwrite & (e.dest != '0);
  endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// In-flight instruction shift register (EX..WB) with multi-cycle EX hold
// counter and bubble insertion behind a held EX entry.
module pipe_scoreboard
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned MC_LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_valid,
  input  sb_entry_t             ld_entry,
  input  logic                  ld_mc,
  output sb_entry_t [DEPTH-1:0] ent,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(MC_LAT + 1);

  logic [CW-1:0] cnt;

  assign busy = (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent <= '0;
      cnt <= '0;
    end else if (busy) begin
      // EX is occupied: keep entry 0, drain everything behind it with a bubble at MEM.
      for (int unsigned k = 2; k < DEPTH; k++) ent[k] <= ent[k-1];
      ent[1] <= '0;
      cnt    <= cnt - 1'b1;
    end else begin
      for (int unsigned k = 1; k < DEPTH; k++) ent[k] <= ent[k-1];
      ent[0] <= ld_valid ? ld_entry : '0;
      cnt    <= (ld_valid && ld_mc) ? CW'(MC_LAT - 1) : '0;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard-based hazard, forwarding and stall controller for the in-order pipeline.
// Optional forwarding is enabled by defining PIPE_FWD_EN; otherwise every RAW hazard stalls.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_AVAIL = 2,
  parameter int unsigned MC_LAT     = 4,
  parameter int unsigned FW_W       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_regwrite,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_is_load,
  input  logic              id_is_mc,
  input  logic              id_is_branch,
  input  logic              id_br_taken,
  output logic              stall,
  output logic              id_bubble,
  output logic              ex_hold,
  output logic              mem_bubble,
  output logic              flush_if,
  output logic [FW_W-1:0]   fwd_a,
  output logic [FW_W-1:0]   fwd_b,
  output logic              mc_busy
);

  sb_entry_t [DEPTH-1:0] ent;
  sb_entry_t             id_ent;
  logic                  busy;
  logic                  raw_haz;
  logic                  unused_ent;

  always_comb begin
    id_ent          = '0;
    id_ent.valid    = 1'b1;
    id_ent.regwrite = id_regwrite;
    id_ent.dest     = SB_AW'(id_dest);
    id_ent.is_load  = id_is_load;
    id_ent.rs       = SB_AW'(id_rs);
    id_ent.rt       = SB_AW'(id_rt);
    id_ent.uses_rs  = id_uses_rs;
    id_ent.uses_rt  = id_uses_rt;
  end

  pipe_scoreboard #(
    .DEPTH  (DEPTH),
    .MC_LAT (MC_LAT)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_valid (id_valid & ~stall),
    .ld_entry (id_ent),
    .ld_mc    (id_is_mc),
    .ent      (ent),
    .busy     (busy)
  );

  always_comb begin
    logic hit;
    raw_haz = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      hit = 1'b0;
      if (is_writer(ent[k])) begin
`ifdef PIPE_FWD_EN
        // Too young to forward, or a branch compares in ID before any forward point.
        hit = (k + 1 < (ent[k].is_load ? LOAD_AVAIL : 1)) | (id_is_branch & (k < DEPTH - 1));
`else
        hit = (k < DEPTH - 1);
`endif
      end
      if (hit && ((id_uses_rs && ent[k].dest == SB_AW'(id_rs)) ||
                  (id_uses_rt && ent[k].dest == SB_AW'(id_rt))))
        raw_haz = 1'b1;
    end
    raw_haz = raw_haz & id_valid;
  end

  assign stall      = busy | raw_haz;
  assign id_bubble  = stall & ~busy;
  assign ex_hold    = busy;
  assign mem_bubble = busy;
  assign mc_busy    = busy;
  assign flush_if   = rst_n & id_valid & id_is_branch & id_br_taken & ~stall;

`ifdef PIPE_FWD_EN
  always_comb begin
    fwd_a = FW_W'(FWD_IDFILE);
    fwd_b = FW_W'(FWD_IDFILE);
    // Scan oldest to youngest so the youngest matching producer overrides.
    for (int unsigned k = DEPTH - 1; k >= 1; k--) begin
      if (is_writer(ent[k]) && (!ent[k].is_load || k >= LOAD_AVAIL) && ent[0].valid) begin
        if (ent[0].uses_rs && ent[k].dest == ent[0].rs) fwd_a = FW_W'(k);
        if (ent[0].uses_rt && ent[k].dest == ent[0].rt) fwd_b = FW_W'(k);
      end
    end
  end
`else
  assign fwd_a = FW_W'(FWD_IDFILE);
  assign fwd_b = FW_W'(FWD_IDFILE);
`endif

  assign unused_ent = ^ent;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed test-plan steps followed by
// random instruction streams, all checked against an instruction-level pipeline model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned REG_AW     = 5;
  localparam int unsigned DEPTH      = 3;
  localparam int unsigned LOAD_AVAIL = 2;
  localparam int unsigned MC_LAT     = 4;
  localparam int unsigned FW_W       = $clog2(DEPTH);
`ifdef PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              id_valid, id_uses_rs, id_uses_rt, id_regwrite;
  logic              id_is_load, id_is_mc, id_is_branch, id_br_taken;
  logic [REG_AW-1:0] id_rs, id_rt, id_dest;
  logic              stall, id_bubble, ex_hold, mem_bubble, flush_if, mc_busy;
  logic [FW_W-1:0]   fwd_a, fwd_b;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_AW     (REG_AW),
    .DEPTH      (DEPTH),
    .LOAD_AVAIL (LOAD_AVAIL),
    .MC_LAT     (MC_LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_regwrite  (id_regwrite),
    .id_dest      (id_dest),
    .id_is_load   (id_is_load),
    .id_is_mc     (id_is_mc),
    .id_is_branch (id_is_branch),
    .id_br_taken  (id_br_taken),
    .stall        (stall),
    .id_bubble    (id_bubble),
    .ex_hold      (ex_hold),
    .mem_bubble   (mem_bubble),
    .flush_if     (flush_if),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .mc_busy      (mc_busy)
  );

  // Model: the instruction occupying each post-ID stage, plus remaining EX hold cycles.
  typedef struct {
    bit valid, rw, load, urs, urt;
    int dest, rs, rt;
  } instr_t;

  instr_t stage[DEPTH];
  int     hold_left = 0;
  int     errors = 0;
  int     checks = 0;
  bit     e_stall, e_hold, e_flush;
  int     e_fa, e_fb;
  int     o_fa, o_fb, n_stall;
  bit     o_stall, o_flush, n_flush;

  function automatic bit produces(instr_t p);
    return p.valid && p.rw && p.dest != 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < DEPTH; k++) stage[k] = '{default: 0};
    hold_left = 0;
  endtask

  task automatic model_eval();
    bit haz;
    haz    = 0;
    e_hold = hold_left > 0;
    for (int k = 0; k < DEPTH; k++) begin
      bit reads;
      bit blocks;
      int ready_at;
      reads    = (id_uses_rs && stage[k].dest == int'(id_rs)) ||
                 (id_uses_rt && stage[k].dest == int'(id_rt));
      ready_at = stage[k].load ? LOAD_AVAIL : 1;
      if (FWD) blocks = (k + 1 < ready_at) || (id_is_branch && k < DEPTH - 1);
      else     blocks = (k < DEPTH - 1);
      if (id_valid && produces(stage[k]) && reads && blocks) haz = 1;
    end
    e_stall = e_hold || haz;
    e_flush = id_valid && id_is_branch && id_br_taken && !e_stall;
    e_fa = 0;
    e_fb = 0;
    if (FWD && stage[0].valid) begin
      for (int k = 1; k < DEPTH; k++) begin
        if (produces(stage[k]) && (!stage[k].load || k >= LOAD_AVAIL)) begin
          if (e_fa == 0 && stage[0].urs && stage[k].dest == stage[0].rs) e_fa = k;
          if (e_fb == 0 && stage[0].urt && stage[k].dest == stage[0].rt) e_fb = k;
        end
      end
    end
  endtask

  task automatic model_step();
    if (hold_left > 0) begin
      for (int k = DEPTH - 1; k >= 2; k--) stage[k] = stage[k-1];
      stage[1] = '{default: 0};
      hold_left--;
    end else begin
      for (int k = DEPTH - 1; k >= 1; k--) stage[k] = stage[k-1];
      stage[0] = '{default: 0};
      if (id_valid && !e_stall) begin
        stage[0] = '{valid: 1, rw: id_regwrite, load: id_is_load, urs: id_uses_rs,
                     urt: id_uses_rt, dest: int'(id_dest), rs: int'(id_rs), rt: int'(id_rt)};
        if (id_is_mc) hold_left = MC_LAT - 1;
      end
    end
  endtask

  // Entered at posedge+1 with ID inputs set; checks at posedge+3, returns at next posedge+1.
  task automatic cycle();
    #2;
    model_eval();
    chk("stall", stall, e_stall);
    chk("id_bubble", id_bubble, e_stall && !e_hold);
    chk("ex_hold", ex_hold, e_hold);
    chk("mem_bubble", mem_bubble, e_hold);
    chk("mc_busy", mc_busy, e_hold);
    chk("flush_if", flush_if, e_flush);
    chk("fwd_a", fwd_a, e_fa);
    chk("fwd_b", fwd_b, e_fb);
    o_stall = stall;
    o_flush = flush_if;
    o_fa    = int'(fwd_a);
    o_fb    = int'(fwd_b);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_id(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input bit rw, input int dest, input bit ld, input bit mc,
                        input bit br, input bit tk);
    id_valid     = v;
    id_rs        = REG_AW'(rs);
    id_rt        = REG_AW'(rt);
    id_uses_rs   = urs;
    id_uses_rt   = urt;
    id_regwrite  = rw;
    id_dest      = REG_AW'(dest);
    id_is_load   = ld;
    id_is_mc     = mc;
    id_is_branch = br;
    id_br_taken  = tk;
  endtask

  // Present one instruction in ID until it issues; counts observed stall cycles.
  task automatic issue(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input bit rw, input int dest, input bit ld, input bit mc,
                       input bit br, input bit tk);
    set_id(v, rs, rt, urs, urt, rw, dest, ld, mc, br, tk);
    n_stall = 0;
    n_flush = 0;
    for (int n = 0; n < 20; n++) begin
      cycle();
      if (o_flush) n_flush = 1;
      if (o_stall) n_stall++;
      if (!e_stall) return;
    end
    checks++;
    errors++;
    $error("FAIL issue_timeout observed=stalled expected=issue within 20 cycles");
  endtask

  task automatic nop();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alu(input int dest, input int rs, input int rt);
    issue(1, rs, rt, 1, 1, 1, dest, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH; i++) nop();
  endtask

  initial begin
    model_clear();
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    #1 rst_n = 1'b0;
    #3;
    chk("rst_stall", stall, 0);
    chk("rst_id_bubble", id_bubble, 0);
    chk("rst_ex_hold", ex_hold, 0);
    chk("rst_mem_bubble", mem_bubble, 0);
    chk("rst_flush_if", flush_if, 0);
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_fwd_b", fwd_b, 0);
    chk("rst_mc_busy", mc_busy, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    nop();

    // Back-to-back ALU dependency
    alu(8, 1, 2);
    alu(10, 8, 2);
    chk("t1_stall_cycles", n_stall, FWD ? 0 : 2);
    nop();
    chk("t1_fwd_a", o_fa, FWD ? 1 : 0);
    drain();

    // One independent instruction in between
    alu(8, 1, 2);
    alu(9, 1, 2);
    alu(10, 8, 2);
    nop();
    chk("t1b_fwd_a", o_fa, FWD ? 2 : 0);
    drain();

    // Load-use
    issue(1, 1, 2, 1, 0, 1, 8, 1, 0, 0, 0);
    alu(10, 3, 8);
    chk("t2_stall_cycles", n_stall, FWD ? 1 : 2);
    nop();
    chk("t2_fwd_b", o_fb, FWD ? 2 : 0);
    drain();

    // Multi-cycle op
    issue(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0);
    alu(11, 1, 2);
    chk("t3_hold_cycles", n_stall, MC_LAT - 1);
    drain();

    // Taken branches
    issue(1, 1, 2, 1, 1, 0, 0, 0, 0, 1, 1);
    chk("t4_free_stall", n_stall, 0);
    chk("t4_free_flush", n_flush, 1);
    alu(8, 1, 2);
    issue(1, 8, 0, 1, 1, 0, 0, 0, 0, 1, 1);
    chk("t4_dep_stall", n_stall, 2);
    chk("t4_dep_flush", n_flush, 1);
    drain();

    // Writer to $0 never creates a dependency
    alu(0, 1, 2);
    alu(10, 0, 2);
    chk("t5_stall_cycles", n_stall, 0);
    nop();
    chk("t5_fwd_a", o_fa, 0);
    drain();

    // Reset in the middle of a multi-cycle hold
    issue(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0);
    set_id(1, 1, 2, 1, 1, 1, 12, 0, 0, 0, 0);
    cycle();
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    chk("t6_stall", stall, 0);
    chk("t6_ex_hold", ex_hold, 0);
    chk("t6_mem_bubble", mem_bubble, 0);
    chk("t6_mc_busy", mc_busy, 0);
    chk("t6_id_bubble", id_bubble, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    alu(12, 1, 2);
    chk("t6_post_stall", n_stall, 0);
    drain();

    // Random instruction stream
    for (int i = 0; i < 300; i++) begin
      bit v, br, mc, ld;
      v  = ($urandom % 5) != 0;
      br = v && (($urandom % 6) == 0);
      mc = v && !br && (($urandom % 10) == 0);
      ld = v && !br && !mc && (($urandom % 4) == 0);
      if (!v)
        nop();
      else
        issue(1, int'($urandom % 4), int'($urandom % 4), bit'($urandom % 2), bit'($urandom % 2),
              !br && bit'($urandom % 4 != 0), int'($urandom % 4), ld, mc, br, bit'($urandom % 2));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=no finish expected=finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard, forwarding and stall controller for the in-order MIPS pipeline. It replaces the separate combinational hazard and forwarding units with one scoreboard: a shift register of in-flight writers from EX to WB. It adds configurable post-ID depth, configurable load-data availability, and multi-cycle EX ops (mult/div) with a counted EX hold.

Parameters:
REG_AW, 5, register address width
DEPTH, 3, post-ID stages tracked; entry 0 = EX, entry DEPTH-1 = WB (min 2)
LOAD_AVAIL, 2, first entry index at which a load result can be forwarded (1..DEPTH-1)
MC_LAT, 4, EX occupancy in cycles of a multi-cycle op (>=1)
FW_W, $clog2(DEPTH), width of a forward-select field

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs, id_rt  in  REG_AW  ID source registers
id_uses_rs, id_uses_rt  in  1  source is actually read
id_regwrite  in  1  ID instruction writes a register
id_dest  in  REG_AW  destination (post RegDst)
id_is_load  in  1  ID is a load
id_is_mc  in  1  ID is a multi-cycle EX op
id_is_branch  in  1  ID is beq/bne (operands compared in ID)
id_br_taken  in  1  branch condition true, or jump
stall  out  1  hold PC and IF/ID
id_bubble  out  1  zero ID/EX control signals this cycle
ex_hold  out  1  hold ID/EX (multi-cycle op in EX)
mem_bubble  out  1  zero EX/MEM controls this cycle
flush_if  out  1  clear IF/ID (taken branch/jump)
fwd_a, fwd_b  out  FW_W  EX operand source: 0 = ID/EX value, k = result in entry k
mc_busy  out  1  multi-cycle counter nonzero

Behaviour:
- Entry fields: valid, regwrite, dest, is_load, rs, rt, uses_rs, uses_rt. Writer(e) = valid & regwrite & dest!=0.
- Reset (async): all entries invalid, cnt=0. All outputs are 0 while rst_n is low and after release.
- ex_hold = mc_busy = (cnt!=0).
- Load-use stall: when ID source s is used, stall if there is any writer entry k with dest==s and k+1 < avail, where avail = LOAD_AVAIL for loads and 1 otherwise.
- Branch stall: id_is_branch and a used source matches a writer in entries 0..DEPTH-2. WB entry is excluded because the regfile is write-through.
- stall = ex_hold | load-use | branch stall.
- id_bubble = stall & ~ex_hold.
- flush_if = id_valid & id_is_branch & id_br_taken & ~stall. A taken branch while stalled is deferred until operands resolve.
- Shift when ~ex_hold: entry[k+1] <= entry[k], and entry[0] <= ID fields if id_valid & ~stall, else invalid. The entry at DEPTH-1 retires.
- Shift when ex_hold: entry[0] holds, entry[1] <= invalid, entries 2.. shift. mem_bubble = ex_hold.
- cnt: when an is_mc instruction loads into entry 0, cnt <= MC_LAT-1; if ex_hold, cnt decrements. MC_LAT=1 means no hold.
- fwd_a: the smallest k in 1..DEPTH-1 such that entry[0].uses_rs, entry k is a writer, entry k's dest == entry[0].rs, and (is_load ? k>=LOAD_AVAIL : 1); else 0. fwd_b is the same using rt. The youngest matching producer wins.
- fwd_* are combinational from the scoreboard and valid in every cycle, including during ex_hold.
- Simultaneous stall and flush: stall wins; flush_if stays 0.

Optional Feature:
PIPE_FWD_EN.
- Defined: forwarding as above.
- Undefined: fwd_a/fwd_b are tied to 0. Every ID source that matches a writer in entries 0..DEPTH-2 stalls, with the same rule as the branch stall. Load-use logic is subsumed by this rule.

Decomposition:
- Package pipe_hazard_pkg: sb_entry_t struct, FWD_IDFILE=0 constant, fwd select typedef.
- Sub-module pipe_scoreboard: entry shift register plus hold/bubble insertion. Instantiated once. Match, stall and forward logic stay in the top.

Test Plan:
(DEPTH=3, LOAD_AVAIL=2, MC_LAT=4, PIPE_FWD_EN defined unless stated)
1. add $8 then add using rs=$8 -> next cycle fwd_a=1, no stall. With one independent op between them -> fwd_a=2.
2. lw $8 then add using rt=$8 -> stall=id_bubble=1 for exactly 1 cycle, then fwd_b=2.
3. mult enters EX -> ex_hold=stall=mem_bubble=1 for 3 cycles, mc_busy falls on the 4th, and the following instruction issues on the next cycle.
4. Taken beq with no dependency -> flush_if=1 for 1 cycle. beq on $8 right after add $8 -> stall for 2 cycles, then flush_if=1.
5. Writer with dest=$0 followed by a reader of $0 -> fwd=0 and no stall. With PIPE_FWD_EN undefined, test 1 instead gives stall=1 for 2 cycles and fwd always 0.
6. rst_n low during the mult hold -> outputs 0 asynchronously and cnt cleared. After release, the first new instruction issues without stall.
